// File: rtl/ad_capture_ctrl.sv
`default_nettype none
// ============================================================================
// ad_capture_ctrl : triggered ADC capture with delay, decimation and word packing
// Optional: AD_CAPTURE_AVG_EN (group mean instead of first sample). Rev 1.0
// ============================================================================
module ad_capture_ctrl #(
   parameter int AD_DATA_SIZE = 8,
   parameter int PACK         = 2,
   parameter int CNT_W        = 16
) (
   input  logic                         i_ad_clk,
   input  logic                         i_rst_n,
   input  logic                         i_trig_int,
   input  logic                         i_trig_ext,
   input  logic                         i_trig_sel,
   input  logic [CNT_W-1:0]             i_delay,
   input  logic [CNT_W-1:0]             i_recv_count,
   input  logic [1:0]                   i_decim_log2,
   input  logic [AD_DATA_SIZE-1:0]      i_ad_data,
   output logic [AD_DATA_SIZE*PACK-1:0] o_data,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic                         o_ad_open,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_overrun
);
   localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
   localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(PACK - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DELAY   = 2'd1,
      COLLECT = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   state_t                         r_state;
   logic                           r_sync1, r_sync2, r_sync3, r_trig_edge;
   logic [AD_DATA_SIZE-1:0]        r_ad;
   logic                           r_smp_vld;
   logic [CNT_W-1:0]               r_cnt, r_delay, r_count;
   logic [1:0]                     r_k;
   logic [2:0]                     r_dcnt;
   logic [LANE_W-1:0]              r_lane;
   logic [AD_DATA_SIZE*PACK-1:0]   r_pack;

   logic [2:0]                     w_grp_mask;
   logic                           w_take, w_grp_end, w_final, w_word_done, w_load;
   logic [CNT_W-1:0]               w_cnt_inc;
   logic [AD_DATA_SIZE-1:0]        w_dec;
   logic [AD_DATA_SIZE*PACK-1:0]   w_word;

   // Synchroniser presets to 1 so a trigger already high at reset gives no edge
   always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_sync3     <= 1'b1;
         r_trig_edge <= 1'b0;
         r_ad        <= '0;
         r_smp_vld   <= 1'b0;
      end else begin
         r_sync1     <= i_trig_sel ? i_trig_ext : i_trig_int;
         r_sync2     <= r_sync1;
         r_sync3     <= r_sync2;
         r_trig_edge <= r_sync2 & ~r_sync3;
         r_ad        <= i_ad_data;
         r_smp_vld   <= (r_state == COLLECT);
      end
   end

   assign w_grp_mask  = 3'b111 >> (2'd3 - r_k);
   assign w_take      = (r_state == COLLECT) && r_smp_vld;
   assign w_grp_end   = (r_dcnt == w_grp_mask);
   assign w_cnt_inc   = r_cnt + CNT_W'(1);
   assign w_final     = w_grp_end && (w_cnt_inc == r_count);
   assign w_word_done = w_take && w_grp_end && ((r_lane == c_last_lane) || w_final);
   assign w_load      = w_word_done && (!o_valid || i_ready);

`ifdef AD_CAPTURE_AVG_EN
   logic [AD_DATA_SIZE+2:0] r_acc;
   logic [AD_DATA_SIZE+2:0] w_sum;

   assign w_sum = r_acc + {3'b000, r_ad};
   assign w_dec = AD_DATA_SIZE'(w_sum >> r_k);

   always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_acc <= '0;
      else if (r_state == IDLE)
         r_acc <= '0;
      else if (w_take)
         r_acc <= w_grp_end ? '0 : w_sum;
   end
`else
   logic [AD_DATA_SIZE-1:0] r_first;

   assign w_dec = (r_dcnt == 3'd0) ? r_ad : r_first;

   always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_first <= '0;
      else if (w_take && (r_dcnt == 3'd0))
         r_first <= r_ad;
   end
`endif

   // Lanes above the current one are still zero, which pads a short final word
   always_comb begin
      w_word = r_pack;
      for (int i = 0; i < PACK; i++) begin
         if (r_lane == LANE_W'(i))
            w_word[i*AD_DATA_SIZE +: AD_DATA_SIZE] = w_dec;
      end
   end

   always_ff @(posedge i_ad_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_delay   <= '0;
         r_count   <= '0;
         r_k       <= '0;
         r_dcnt    <= '0;
         r_lane    <= '0;
         r_pack    <= '0;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_ad_open <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (w_load) begin
            o_data  <= w_word;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
         if (w_word_done && !w_load)
            o_overrun <= 1'b1;

         if (w_take) begin
            r_dcnt <= w_grp_end ? 3'd0 : r_dcnt + 3'd1;
            if (w_grp_end) begin
               if (w_word_done) begin
                  r_pack <= '0;
                  r_lane <= '0;
               end else begin
                  r_pack <= w_word;
                  r_lane <= r_lane + LANE_W'(1);
               end
            end
         end

         case (r_state)
            IDLE: begin
               if (r_trig_edge) begin
                  r_delay   <= i_delay;
                  r_count   <= i_recv_count;
                  r_k       <= i_decim_log2;
                  r_cnt     <= '0;
                  r_dcnt    <= '0;
                  r_lane    <= '0;
                  r_pack    <= '0;
                  o_overrun <= 1'b0;
                  o_busy    <= 1'b1;
                  o_ad_open <= 1'b1;
                  if (i_recv_count == '0)
                     r_state <= FLUSH;
                  else if (i_delay == '0)
                     r_state <= COLLECT;
                  else
                     r_state <= DELAY;
               end
            end
            DELAY: begin
               if (w_cnt_inc == r_delay) begin
                  r_cnt   <= '0;
                  r_state <= COLLECT;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            COLLECT: begin
               if (w_take && w_grp_end) begin
                  if (w_final)
                     r_state <= FLUSH;
                  else
                     r_cnt <= w_cnt_inc;
               end
            end
            FLUSH: begin
               if (!o_valid) begin
                  r_state   <= IDLE;
                  o_busy    <= 1'b0;
                  o_ad_open <= 1'b0;
                  o_done    <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ad_capture_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ad_capture_ctrl : randomized scoreboard bench for ad_capture_ctrl
// Rev 1.0
// ============================================================================
module tb_ad_capture_ctrl;
   localparam int W  = 8;
   localparam int PACK = 2;
   localparam int AW = W * PACK;
   localparam int NT = 16384;

   logic          clk;
   logic          i_rst_n;
   logic          i_trig_int, i_trig_ext, i_trig_sel;
   logic [15:0]   i_delay, i_recv_count;
   logic [1:0]    i_decim_log2;
   logic [W-1:0]  i_ad_data;
   logic [AW-1:0] o_data;
   logic          o_valid, i_ready, o_ad_open, o_busy, o_done, o_overrun;

   ad_capture_ctrl #(.AD_DATA_SIZE(W), .PACK(PACK), .CNT_W(16)) dut (
      .i_ad_clk(clk), .i_rst_n(i_rst_n),
      .i_trig_int(i_trig_int), .i_trig_ext(i_trig_ext), .i_trig_sel(i_trig_sel),
      .i_delay(i_delay), .i_recv_count(i_recv_count), .i_decim_log2(i_decim_log2),
      .i_ad_data(i_ad_data), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_ad_open(o_ad_open), .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
   );

   logic [W-1:0]  data_tab [NT];
   bit            rdy_tab  [NT];
   int            cyc;
   int            n_cmp, n_bad;
   logic [AW-1:0] exp_q [$];
   int            done_q [$];
   int            free_at, b_lo, b_hi;
   bit            exp_ovr, last_ovr, held;
   logic [AW-1:0] held_data;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // data_tab[n] is driven after edge n; rdy_tab[n] is the ready seen at edge n
   initial begin
      cyc = 0;
      i_ad_data = '0;
      i_ready = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         i_ad_data = data_tab[cyc];
         i_ready   = rdy_tab[cyc+1];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #2;
      end
   endtask

   always @(negedge clk) begin
      if (i_rst_n) begin
         chk("busy", 32'(o_busy), 32'(cyc >= b_lo && cyc < b_hi));
         chk("ad_open", 32'(o_ad_open), 32'(cyc >= b_lo && cyc < b_hi));
         if (o_valid) begin
            if (held) chk("data_stable", 32'(o_data), 32'(held_data));
            if (i_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL word_unexpected: got %0h, expected no word", o_data);
               end else begin
                  chk("word", 32'(o_data), 32'(exp_q.pop_front()));
               end
               held = 1'b0;
            end else begin
               held = 1'b1;
               held_data = o_data;
            end
         end else begin
            held = 1'b0;
         end
         if (o_done) begin
            if (done_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL done_unexpected: got pulse at %0d, expected none", cyc);
            end else begin
               chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
               chk("overrun_at_done", 32'(o_overrun), 32'(exp_ovr));
            end
         end
      end
   end

   // Reference: raw sample n is data_tab[n]; collection starts at E = trigger edge + 3 + delay
   task automatic start_capture(input int d, input int cnt, input int k, input int rmode,
                                input int step, output int t, output int dn);
      int c0, E, G, P, e, a, base, lane;
      logic [15:0] sum;
      logic [W-1:0] dv;
      logic [AW-1:0] word;
      bit drop, sel;
      sel = 1'($urandom_range(0, 1));
      i_trig_sel = sel;
      if (sel) i_trig_int = 1'b1; else i_trig_ext = 1'b1;
      wait_to(cyc + 4);
      i_trig_int = 1'b0;
      i_trig_ext = 1'b0;
      wait_to(cyc + 5);
      chk("overrun_sticky", 32'(o_overrun), 32'(last_ovr));
      t = cyc; c0 = t + 1; G = 1 << k; E = c0 + 3 + d;
      for (int i = t + 2; i < t + 2 + d + cnt * G + 40; i++) begin
         if (rmode == 1) rdy_tab[i] = 1'b1;
         else if (rmode == 2) rdy_tab[i] = !(i >= E + 3 && i < E + 13);
      end
      if (step != 0)
         for (int i = 0; i < cnt * G; i++) data_tab[E + i] = W'((i + 1) * step);
      drop = 1'b0; word = '0; lane = 0; P = c0 + 3;
      for (int i = 0; i < cnt; i++) begin
         base = E + i * G;
`ifdef AD_CAPTURE_AVG_EN
         sum = '0;
         for (int j = 0; j < G; j++) sum = sum + 16'(data_tab[base + j]);
         dv = W'(sum >> k);
`else
         dv = data_tab[base];
`endif
         word[lane*W +: W] = dv;
         lane++;
         if (lane == PACK || i == cnt - 1) begin
            e = base + G - 1 + 2;
            if (e >= free_at) begin
               exp_q.push_back(word);
               a = e + 1;
               while (a < NT - 1 && !rdy_tab[a]) a++;
               free_at = a;
            end else begin
               drop = 1'b1;
            end
            P = e; word = '0; lane = 0;
         end
      end
      dn = (P + 1 > free_at + 1) ? P + 1 : free_at + 1;
      done_q.push_back(dn);
      exp_ovr = drop; b_lo = t + 4; b_hi = dn;
      i_delay = 16'(d); i_recv_count = 16'(cnt); i_decim_log2 = 2'(k);
      if (sel) i_trig_ext = 1'b1; else i_trig_int = 1'b1;
      wait_to(t + 4);
      i_delay = 16'($urandom); i_recv_count = 16'($urandom); i_decim_log2 = 2'($urandom);
      wait_to(t + 5);
      chk("overrun_cleared", 32'(o_overrun), 32'd0);
   endtask

   task automatic run_capture(input int d, input int cnt, input int k, input int rmode, input int step);
      int t, dn;
      start_capture(d, cnt, k, rmode, step, t, dn);
      if (dn >= t + 13) begin
         if (i_trig_sel) i_trig_ext = 1'b0; else i_trig_int = 1'b0;
         wait_to(t + 7);
         if (i_trig_sel) i_trig_ext = 1'b1; else i_trig_int = 1'b1;
      end
      wait_to(dn + 3);
      chk("done_seen", 32'(done_q.size()), 32'd0);
      done_q.delete();
      i_trig_int = 1'b0;
      i_trig_ext = 1'b0;
      last_ovr = exp_ovr;
   endtask

   initial begin
      int t, dn;
      n_cmp = 0; n_bad = 0; free_at = 0; b_lo = 0; b_hi = 0;
      exp_ovr = 1'b0; last_ovr = 1'b0; held = 1'b0; held_data = '0;
      for (int i = 0; i < NT; i++) begin
         data_tab[i] = W'($urandom);
         case ((i / 64) % 3)
            0:       rdy_tab[i] = 1'b1;
            1:       rdy_tab[i] = ($urandom_range(0, 3) != 0);
            default: rdy_tab[i] = ($urandom_range(0, 3) == 0);
         endcase
      end
      i_rst_n = 1'b0; i_trig_sel = 1'b0; i_trig_int = 1'b1; i_trig_ext = 1'b0;
      i_delay = '0; i_recv_count = '0; i_decim_log2 = '0;
      wait_to(4);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_open", 32'(o_ad_open), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_overrun", 32'(o_overrun), 32'd0);
      i_rst_n = 1'b1;
      // trigger held high through reset must not start a capture
      wait_to(cyc + 10);
      i_trig_int = 1'b0;
      wait_to(cyc + 5);

      run_capture(0, 6, 0, 1, 1);
      run_capture(4, 3, 0, 1, 1);
      run_capture(0, 2, 2, 1, 4);
      run_capture(0, 8, 0, 2, 0);
      run_capture(0, 0, 0, 0, 0);
      run_capture(3, 0, 2, 0, 0);

      start_capture(0, 9, 1, 1, 0, t, dn);
      wait_to(t + 12);
      #1;
      i_rst_n = 1'b0;
      #1;
      chk("async_rst_data", 32'(o_data), 32'd0);
      chk("async_rst_valid", 32'(o_valid), 32'd0);
      chk("async_rst_open", 32'(o_ad_open), 32'd0);
      chk("async_rst_busy", 32'(o_busy), 32'd0);
      chk("async_rst_overrun", 32'(o_overrun), 32'd0);
      exp_q.delete(); done_q.delete();
      free_at = 0; b_hi = cyc; held = 1'b0; last_ovr = 1'b0;
      i_trig_int = 1'b0; i_trig_ext = 1'b0;
      wait_to(cyc + 3);
      i_rst_n = 1'b1;
      wait_to(cyc + 3);
      run_capture(2, 7, 0, 1, 3);

      for (int n = 0; n < 30 && cyc < 12000; n++)
         run_capture($urandom_range(0, 6), $urandom_range(0, 9), $urandom_range(0, 3), 0, 0);

      wait_to(cyc + 5);
      chk("leftover_words", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
